// File: rtl/rf_sched_pkg.sv
// Shared widths and the write-request payload for the register-file write scheduler.
package rf_sched_pkg;

  localparam int unsigned XLEN_D = 32;
  localparam int unsigned NREG_D = 32;
  localparam int unsigned RAW    = 5;

  typedef struct packed {
    logic [RAW-1:0]    rd;
    logic [XLEN_D-1:0] wd;
  } wr_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small FIFO of pending long-latency results waiting for a free Writeback port slot.
// Occupancy flags are kept in flops so full/empty are clean registered signals.
module rf_wb_fifo
  import rf_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push_i,
  input  wr_req_t push_data_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output wr_req_t head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wr_req_t         mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            push_ok;
  logic            pop_ok;

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == CW'(0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is datapath only; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates the two register-file write ports between Execute, Writeback and a
// long-latency unit, and tracks pending long-latency destinations for decode stalls.
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_D,
  parameter int unsigned NREG  = NREG_D,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  input  logic [RAW-1:0]  iss_rd,
  input  logic [RAW-1:0]  rs1,
  input  logic [RAW-1:0]  rs2,
  output logic            hazard_stall,
  input  logic            e_we,
  input  logic [RAW-1:0]  e_rd,
  input  logic [XLEN-1:0] e_wd,
  input  logic            w_we,
  input  logic [RAW-1:0]  w_rd,
  input  logic [XLEN-1:0] w_wd,
  input  logic            m_valid,
  input  logic [RAW-1:0]  m_rd,
  input  logic [XLEN-1:0] m_wd,
  output logic            m_ready,
  output logic            RegWE_E,
  output logic [RAW-1:0]  A3,
  output logic [XLEN-1:0] WD3,
  output logic            RegWE_W,
  output logic [RAW-1:0]  A4,
  output logic [XLEN-1:0] WD4,
  output logic            waw_err
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            waw_q, waw_d;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            commit;
  wr_req_t         fifo_head;
  wr_req_t         m_req;

  assign m_req     = '{rd: m_rd, wd: XLEN_D'(m_wd)};
  assign m_ready   = reset & ~fifo_full;
  assign fifo_push = m_valid & m_ready;
  // The FIFO head only gets the Writeback port when the Writeback stage leaves it idle.
  assign commit    = reset & ~w_we & ~fifo_empty;

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (m_req),
    .pop_i       (commit),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Execute port passthrough, held quiet while reset is asserted.
  always_comb begin
    RegWE_E = 1'b0;
    A3      = '0;
    WD3     = '0;
    if (reset) begin
      RegWE_E = e_we;
      A3      = e_rd;
      WD3     = e_wd;
    end
  end

  // Writeback port mux; a head targeting x0 is consumed without a write.
  always_comb begin
    RegWE_W = 1'b0;
    A4      = '0;
    WD4     = '0;
    if (reset) begin
      if (w_we) begin
        RegWE_W = 1'b1;
        A4      = w_rd;
        WD4     = w_wd;
      end else if (!fifo_empty && (fifo_head.rd != '0)) begin
        RegWE_W = 1'b1;
        A4      = fifo_head.rd;
        WD4     = XLEN'(fifo_head.wd);
      end
    end
  end

  assign hazard_stall = reset & (busy_q[rs1] | busy_q[rs2] |
                                 (iss_valid & (busy_q[iss_rd] | fifo_full)));

  // Scoreboard: a same-cycle issue to the committing register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (commit) begin
      busy_d[fifo_head.rd] = 1'b0;
    end
    if (iss_valid) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    waw_d = waw_q
          | (e_we & (e_rd != '0) & busy_q[e_rd])
          | (w_we & (w_rd != '0) & busy_q[w_rd]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      waw_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      waw_q  <= waw_d;
    end
  end

  assign waw_err = waw_q;

endmodule
